rr_sel_arbiter: RTL

//  Round-robin arbiter that sits directly upstream of the 4:1 select mux.
//  - Picks one of four requesting channels and drives the mux select for it.
//  - Holds that select stable until the channel releases or a hold timeout expires.
//  - Advances priority so that no channel starves.

---
 rtl/rr_sel_arbiter_if.sv | 36 +++
 rtl/rr_sel_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter_if.sv
// Purpose: request/grant bundle between four channels, the arbiter and the 4:1 select mux.
// Latency: none, this is wiring only.
// Backpressure: none; requesters hold req high until they see their grant, then finish with done.
interface rr_sel_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int SEL_W = 2
);

  logic [N_REQ-1:0] req;          // per-channel level request
  logic             done;         // granted channel finished
  logic [SEL_W-1:0] sel;          // mux select, registered in the arbiter
  logic [N_REQ-1:0] grant;        // one-hot grant, zero when idle
  logic             grant_valid;  // a grant is currently held
  logic             timeout;      // one-cycle forced-release pulse

  // Arbiter side: consumes requests, drives select and grant.
  modport master (
    input  req,
    input  done,
    output sel,
    output grant,
    output grant_valid,
    output timeout
  );

  // Requester / mux side: raises requests, observes the grant.
  modport slave (
    output req,
    output done,
    input  sel,
    input  grant,
    input  grant_valid,
    input  timeout
  );

endinterface

// File: rtl/rr_sel_arbiter.sv
// Purpose: round-robin arbiter driving the 4:1 mux select; grant held until done, withdraw or hold timeout.
// Latency: request seen at edge t gives grant after edge t; release takes one edge, then one mandatory idle cycle.
// Backpressure: a held grant ignores other requests; MAX_HOLD bounds how long any channel can block the rest.
module rr_sel_arbiter #(
  parameter int N_REQ    = 4,
  parameter int SEL_W    = 2,
  parameter int MAX_HOLD = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_sel_arbiter_if.master  arb
);

  localparam int              CNT_W     = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [SEL_W-1:0]   sel_q;
  logic [N_REQ-1:0]   grant_q;
  logic               grant_valid_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               win_vld_d;
  logic [SEL_W-1:0]   win_d;
  logic               hold_expired_d;
  logic               release_d;
  logic               timeout_d;

  // Circular priority scan starting at ptr_q; the lowest offset from ptr_q wins.
  // Scanning from the far end down lets the nearest requester overwrite the rest.
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (arb.req[SEL_W'(ptr_q + SEL_W'(i))]) begin
        win_vld_d = 1'b1;
        win_d     = SEL_W'(ptr_q + SEL_W'(i));
      end
    end
  end

  // Release decode for the held grant; timeout is flagged only when nothing else released it.
  always_comb begin
    hold_expired_d = (cnt_q == HOLD_LAST);
    release_d      = arb.done | ~arb.req[sel_q] | hold_expired_d;
    timeout_d      = ~arb.done & arb.req[sel_q] & hold_expired_d;
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      sel_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Any timeout pulse lasts exactly the one idle cycle after release.
          timeout_q <= 1'b0;
          if (win_vld_d) begin
            sel_q         <= win_d;
            grant_q       <= N_REQ'(1) << win_d;
            grant_valid_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= GRANT;
          end
        end
        GRANT: begin
          if (release_d) begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= sel_q + SEL_W'(1);
            timeout_q     <= timeout_d;
            state_q       <= IDLE;
          end else begin
            timeout_q <= 1'b0;
            if (cnt_q != CNT_MAX) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign arb.sel         = sel_q;
  assign arb.grant       = grant_q;
  assign arb.grant_valid = grant_valid_q;
  assign arb.timeout     = timeout_q;

`ifndef SYNTHESIS
  // Structural invariants of the grant outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(grant_q))
        else $error("grant not one-hot");
      assert (grant_valid_q == (|grant_q))
        else $error("grant_valid disagrees with grant");
    end
  end
`endif

endmodule
